// File: rtl/fir_decim_buf.sv
// Keeps one FIR output sample in every M and queues the kept samples in a
// first-word-fall-through FIFO read through a valid/ready handshake.
module fir_decim_buf #(
  parameter int DW    = 10,
  parameter int M     = 4,
  parameter int PHASE = 0,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DW-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DW-1:0]         out_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // A one-bit counter is kept even for M=1 so the width never collapses to zero.
  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(M - 1);
  localparam logic [PW-1:0] KEEP_PHASE = PW'(PHASE);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [PW-1:0]        phase_q, phase_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic signed [DW-1:0] mem_q [DEPTH];

  logic keep;
  logic full;
  logic rd_en;
  logic wr_en;
  logic drop;

  assign out_valid = (level_q != '0);
  // Gate the head so reset and empty present zero instead of stale storage.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

  always_comb begin
    keep       = in_valid && (phase_q == KEEP_PHASE);
    full       = (level_q == FULL_LEVEL);
    rd_en      = !clear && out_valid && out_ready;
    wr_en      = !clear && keep && (!full || rd_en);
    drop       = !clear && keep && full && !rd_en;

    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (clear) begin
      phase_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (in_valid) begin
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage carries no reset; only the pointers and level qualify it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: doc/fir_decim_buf.md
Name: fir_decim_buf

Overview:
- Decimation and buffering stage that sits directly downstream of the FIR filter.
- Takes the filter's Q1.9 output stream, qualified by the same sample strobe that drives the FIR `en`, and keeps one sample in every M.
- Kept samples go into a small first-word-fall-through (FWFT) FIFO, which is read through a valid/ready handshake by the next consumer.
- Flags overflow when the consumer stalls for too long.

Parameters:
- DW, 10, sample width (signed, Q1.9 at default).
- M, 4, decimation factor; legal range 1..256.
- PHASE, 0, index within each group of M of the sample that is kept; legal range 0..M-1.
- DEPTH, 8, FIFO depth in entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; same-cycle priority over every other input.
- in_valid  in  1  input sample strobe.
- in_data  in  DW  signed input sample (FIR output).
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  DW  FIFO head sample, signed.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a kept sample was dropped.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, level=0, overflow=0, phase counter=0, read/write pointers=0.
- Phase counter:
  - Counts 0..M-1.
  - Advances by 1 on each cycle with in_valid=1; wraps M-1 -> 0.
  - Holds when in_valid=0.
  - M=1 means every sample is kept.
- Keep condition: a cycle with in_valid=1 and phase counter == PHASE. Only such cycles generate a write request.
- Handshake:
  - A read occurs on a cycle with out_valid=1 and out_ready=1.
  - out_data must hold stable while out_valid=1 and out_ready=0.
  - out_ready is ignored when out_valid=0.
- FIFO (FWFT):
  - A sample written at edge k is visible at out_data with out_valid=1 after edge k (zero-wait read from empty).
  - out_data is driven from the storage array at the read pointer; out_valid = (level != 0).
- Full handling:
  - A write when level==DEPTH with no read that cycle: the sample is dropped, storage and pointers are unchanged, and overflow is set to 1.
  - A write and a read in the same cycle while full: both succeed, level stays at DEPTH, overflow is not set.
- Empty handling: a write and a read in the same cycle while empty cannot happen, because out_valid=0; the write proceeds normally.
- Level:
  - Increments on write-only.
  - Decrements on read-only.
  - Unchanged on simultaneous read+write or no activity.
- Pointers: $clog2(DEPTH) bits each, wrapping naturally.
- overflow: sticky; cleared only by rst_n low or clear=1.
- clear=1:
  - At the next edge: phase counter=0, pointers=0, level=0, overflow=0.
  - in_valid and out_ready in that cycle are ignored; no write, no read.
- Reset mid-operation: asynchronous assertion of rst_n immediately forces the reset values, with no clock required. Deassertion is assumed synchronised externally.
- Arithmetic: none on data. Samples pass bit-exact; no rounding and no saturation.
- Latency: input edge to out_valid is 1 cycle when the FIFO is empty.

Test Plan:
- Basic decimation (M=4, PHASE=0, DEPTH=8): in_valid=1 continuously, in_data=0,1,...,15, out_ready=1 -> out stream 0,4,8,12; each appears 1 cycle after its input edge; overflow=0.
- Phase offset (PHASE=2): same stimulus -> outputs 2,6,10,14.
- Gapped input: in_valid toggling 1,0,1,0 with data 0..7 on valid cycles -> outputs 0,4; the phase counter does not advance on idle cycles.
- Backpressure and overflow:
  - out_ready=0; feed 0..39 -> level=8 after sample 28, overflow=1 after sample 32 is dropped.
  - Then out_ready=1 -> drains exactly 0,4,...,28 in order, with out_data stable during the stall; level returns to 0.
- Full read/write: fill to level=8, then assert out_ready=1 on a cycle that is also a keep cycle -> level stays 8, overflow stays 0, the new sample lands at the tail.
- Clear and reset:
  - With level=5 and overflow=1, pulse clear together with in_valid -> next cycle level=0, overflow=0, no write, phase counter=0.
  - Repeat, but drive rst_n low mid-cycle -> outputs return to reset values before the next clk edge.
